// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin pipelined memory arbiter.
package mem_arb_pkg;

  // Port 0 is the host DMA requester with absolute priority.
  localparam int unsigned DMA_PORT = 0;

  // Widest port ID needed for the largest legal configuration (16 ports).
  localparam int unsigned PORT_ID_MAX_W = 4;

  typedef logic [PORT_ID_MAX_W-1:0] port_id_t;

  // Bits needed to hold a port ID for a given port count.
  function automatic int unsigned port_id_w(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Synchronous tag FIFO holding the port IDs of reads in flight, in issue order.
module mem_arb_tag_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   din,
  output logic [W-1:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter_rr_pipe.sv
// N-port shared-memory arbiter: DMA port 0 has priority, cores 1..N-1 are
// round-robin, reads are pipelined with in-order responses routed by a tag FIFO.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (forces a core grant after
// STARVE_LIMIT consecutive DMA grants while a core is waiting).
module mem_arbiter_rr_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        valid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_valid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        err_unexp
);

  localparam int unsigned PORT_ID_W = port_id_w(NUM_PORTS);
  localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING+1);

  logic [PORT_ID_W-1:0] tag_head;
  logic [CNT_W-1:0]     tag_count;
  logic                 tag_empty;
  logic                 tag_full;
  logic [NUM_PORTS-1:0] eligible;
  port_id_t             ptr;
  port_id_t             core_win;
  port_id_t             win;
  logic                 core_found;
  logic                 starve_hit;
  logic                 issue;
  logic                 issue_we;
  logic [ADDR_W-1:0]    addr_sel;
  logic [DATA_W-1:0]    wdata_sel;
  logic                 push;
  logic                 pop;

  // Reads need a free tag slot (registered count); writes are never blocked.
  assign eligible = req & (we | {NUM_PORTS{~tag_full}});

  // Round-robin search over cores: first pass from ptr upward, second pass wraps to 1.
  always_comb begin
    core_found = 1'b0;
    core_win   = port_id_t'(1);
    for (int unsigned p = 1; p < NUM_PORTS; p++) begin
      if (!core_found && eligible[p] && (p >= 32'(ptr))) begin
        core_found = 1'b1;
        core_win   = port_id_t'(p);
      end
    end
    for (int unsigned p = 1; p < NUM_PORTS; p++) begin
      if (!core_found && eligible[p] && (p < 32'(ptr))) begin
        core_found = 1'b1;
        core_win   = port_id_t'(p);
      end
    end
  end

  // Final winner selection and mux of the winner's request fields.
  always_comb begin
    win       = port_id_t'(DMA_PORT);
    issue     = 1'b0;
    issue_we  = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (mem_ready) begin
      if (eligible[DMA_PORT] && !starve_hit) begin
        win   = port_id_t'(DMA_PORT);
        issue = 1'b1;
      end else if (core_found) begin
        win   = core_win;
        issue = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (32'(win) == p) begin
        issue_we  = we[p];
        addr_sel  = addr[p*ADDR_W +: ADDR_W];
        wdata_sel = wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  assign push = issue && !issue_we;
  assign pop  = mem_valid && !tag_empty;

  mem_arb_tag_fifo #(
    .W     (PORT_ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (win[PORT_ID_W-1:0]),
    .dout  (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  // Issue stage: registered grant, memory command and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= port_id_t'(1);
    end else begin
      gnt     <= issue ? (NUM_PORTS'(1) << win) : '0;
      mem_req <= issue;
      mem_we  <= issue && issue_we;
      if (issue) begin
        mem_addr  <= addr_sel;
        mem_wdata <= wdata_sel;
      end
      if (issue && (win != port_id_t'(DMA_PORT)))
        ptr <= (32'(win) == NUM_PORTS-1) ? port_id_t'(1) : win + 1'b1;
    end
  end

  // Response stage: route returned data to the port at the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      rdata     <= '0;
      err_unexp <= 1'b0;
    end else begin
      valid <= pop ? (NUM_PORTS'(1) << tag_head) : '0;
      if (pop) rdata <= mem_rdata;
      if (mem_valid && tag_empty) err_unexp <= 1'b1;
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT+1);
  logic [SW-1:0] starve_cnt;

  assign starve_hit = core_found && (starve_cnt >= SW'(STARVE_LIMIT));

  // Count consecutive DMA grants taken while a core was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (issue) begin
      if (win != port_id_t'(DMA_PORT)) starve_cnt <= '0;
      else if (core_found)             starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr_pipe.sv
// Scoreboard bench for mem_arbiter_rr_pipe: expected grants and responses are
// queued as stimulus is driven and checked as the DUT produces them.
module tb_mem_arbiter_rr_pipe;

  localparam int NP = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    int          port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } gexp_t;

  typedef struct {
    int          port;
    logic [63:0] data;
  } rexp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP-1:0]    we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    valid;
  logic [DW-1:0]    rdata;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ready;
  logic             mem_valid;
  logic [DW-1:0]    mem_rdata;
  logic             err_unexp;

  logic [NP-1:0]    sticky;
  gexp_t            gq[$];
  rexp_t            rq[$];
  int               n_tests = 0;
  int               n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr_pipe #(
    .NUM_PORTS       (NP),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (4),
    .STARVE_LIMIT    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .valid     (valid),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .err_unexp (err_unexp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; release granted non-sticky requests.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
        if (gnt[p] && !sticky[p]) req[p] = 1'b0;
    end
  endtask

  task automatic drive(input int p, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic s);
    req[p]            = 1'b1;
    we[p]             = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
    sticky[p]         = s;
  endtask

  task automatic expect_gnt(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
    gexp_t e;
    e.port = p; e.we = w; e.addr = a; e.wdata = d;
    gq.push_back(e);
  endtask

  // One cycle of returned read data; queue the response only when one is due.
  task automatic respond(input int p, input logic [63:0] d, input logic due);
    rexp_t e;
    mem_valid = 1'b1;
    mem_rdata = d;
    if (due) begin
      e.port = p; e.data = d;
      rq.push_back(e);
    end
    step(1);
    mem_valid = 1'b0;
  endtask

  task automatic reset_dut();
    if (gq.size() != 0) check("gq_drain", 64'(gq.size()), 64'd0);
    if (rq.size() != 0) check("rq_drain", 64'(rq.size()), 64'd0);
    gq.delete();
    rq.delete();
    rst_n     = 1'b0;
    req       = '0;
    we        = '0;
    sticky    = '0;
    mem_valid = 1'b0;
    #2;
    check("rst_gnt",   64'(gnt),       64'd0);
    check("rst_valid", 64'(valid),     64'd0);
    check("rst_mreq",  64'(mem_req),   64'd0);
    check("rst_mwe",   64'(mem_we),    64'd0);
    check("rst_err",   64'(err_unexp), 64'd0);
    check("rst_rdata", rdata,          64'd0);
    check("rst_maddr", mem_addr,       64'd0);
    check("rst_mwd",   mem_wdata,      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (rst_n) begin
      if (mem_req != (gnt != '0)) check("req_vs_gnt", 64'(mem_req), 64'(gnt != '0));
      if (gnt != '0) begin
        if (gq.size() == 0) check("gnt_extra", 64'(gnt), 64'd0);
        else begin
          g = gq.pop_front();
          check("gnt",       64'(gnt),    64'd1 << g.port);
          check("mem_we",    64'(mem_we), 64'(g.we));
          check("mem_addr",  mem_addr,    g.addr);
          check("mem_wdata", mem_wdata,   g.wdata);
        end
      end
      if (valid != '0) begin
        if (rq.size() == 0) check("valid_extra", 64'(valid), 64'd0);
        else begin
          r = rq.pop_front();
          check("valid", 64'(valid), 64'd1 << r.port);
          check("rdata", rdata,      r.data);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    we        = '0;
    addr      = '0;
    wdata     = '0;
    sticky    = '0;
    mem_ready = 1'b1;
    mem_valid = 1'b0;
    mem_rdata = '0;
    #12;
    reset_dut();

    // 1: DMA and two cores read together -> 0, 1, 2
    drive(0, 1'b0, 64'hD0, 64'h0, 1'b0);
    drive(1, 1'b0, 64'hA1, 64'h0, 1'b0);
    drive(2, 1'b0, 64'hA2, 64'h0, 1'b0);
    expect_gnt(0, 1'b0, 64'hD0, 64'h0);
    expect_gnt(1, 1'b0, 64'hA1, 64'h0);
    expect_gnt(2, 1'b0, 64'hA2, 64'h0);
    step(3);
    respond(0, 64'h100, 1'b1);
    respond(1, 64'h101, 1'b1);
    respond(2, 64'h102, 1'b1);
    step(2);
    reset_dut();

    // 2: three cores hold writes for 6 cycles -> 1,2,3,1,2,3
    for (int p = 1; p < NP; p++) drive(p, 1'b1, 64'h1000 + 64'(p), 64'h11 * 64'(p), 1'b1);
    for (int k = 0; k < 2; k++)
      for (int p = 1; p < NP; p++) expect_gnt(p, 1'b1, 64'h1000 + 64'(p), 64'h11 * 64'(p));
    step(6);
    req = '0;
    sticky = '0;
    step(2);
    reset_dut();

    // 3: read backpressure at MAX_OUTSTANDING, writes still pass
    drive(1, 1'b0, 64'h40, 64'h0, 1'b1);
    for (int k = 0; k < 4; k++) expect_gnt(1, 1'b0, 64'h40, 64'h0);
    step(4);
    drive(2, 1'b1, 64'h80, 64'h1234, 1'b0);
    expect_gnt(2, 1'b1, 64'h80, 64'h1234);
    step(1);
    check("t3_write", 64'(gnt), 64'h4);
    step(1);
    check("t3_blocked", 64'(gnt), 64'h0);
    sticky[1] = 1'b0;
    expect_gnt(1, 1'b0, 64'h40, 64'h0);
    respond(1, 64'h311, 1'b1);
    check("t3_pop_cycle", 64'(gnt), 64'h0);
    step(1);
    check("t3_5th", 64'(gnt), 64'h2);
    for (int k = 0; k < 4; k++) respond(1, 64'h320 + 64'(k), 1'b1);
    step(2);
    check("t3_err", 64'(err_unexp), 64'd0);
    reset_dut();

    // 4: in-order routing of two reads
    drive(2, 1'b0, 64'h10, 64'h0, 1'b0);
    drive(3, 1'b0, 64'h20, 64'h0, 1'b0);
    expect_gnt(2, 1'b0, 64'h10, 64'h0);
    expect_gnt(3, 1'b0, 64'h20, 64'h0);
    step(2);
    respond(2, 64'hAA, 1'b1);
    respond(3, 64'hBB, 1'b1);
    step(2);
    reset_dut();

    // 5: unexpected response, then reset with a read in flight
    respond(0, 64'h55, 1'b0);
    step(1);
    check("t5_err_set", 64'(err_unexp), 64'd1);
    check("t5_no_valid", 64'(valid), 64'd0);
    step(3);
    check("t5_err_sticky", 64'(err_unexp), 64'd1);
    drive(1, 1'b0, 64'h40, 64'h0, 1'b0);
    expect_gnt(1, 1'b0, 64'h40, 64'h0);
    step(1);
    @(negedge clk);
    #1;
    reset_dut();
    respond(1, 64'h77, 1'b0);
    step(1);
    check("t5_late_err", 64'(err_unexp), 64'd1);
    check("t5_late_valid", 64'(valid), 64'd0);
    reset_dut();

    // 6: DMA and core1 writing continuously
    drive(0, 1'b1, 64'hD00, 64'hDD, 1'b1);
    drive(1, 1'b1, 64'hC1, 64'hCC, 1'b1);
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) expect_gnt(0, 1'b1, 64'hD00, 64'hDD);
      expect_gnt(1, 1'b1, 64'hC1, 64'hCC);
    end
    step(18);
`else
    for (int j = 0; j < 10; j++) expect_gnt(0, 1'b1, 64'hD00, 64'hDD);
    step(10);
`endif
    req = '0;
    sticky = '0;
    step(2);
    @(negedge clk);
    #1;
    check("end_gq", 64'(gq.size()), 64'd0);
    check("end_rq", 64'(rq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
